tt_prog_loader: RTL and testbench

//   Parametrised program loader and run controller for the TinyTapeout CPU top.

---
 rtl/tt_prog_loader_if.sv | 17 +
 rtl/tt_prog_loader.sv | 173 +++++++++++++++++
 tb/tb_tt_prog_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_prog_loader_if.sv
// Byte-stream channel between the pad-level wiring and the program loader:
// command/data bytes flow in, readback bytes flow out.
interface tt_prog_loader_if #(
    parameter int DATA_W = 8
);
    // Valid/ready: a byte moves on a posedge where valid && ready are both 1. The source
    // holds valid and data stable until that edge, and ready never depends on valid.
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/tt_prog_loader.sv
// Program loader and run controller: decodes a byte command stream, writes or reads back
// multi-byte program words, and gates CPU execution.
module tt_prog_loader #(
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    tt_prog_loader_if.slave    bus,
    output logic               mem_we,
    output logic               mem_re,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               cpu_run,
    output logic               busy,
    output logic               err,
    output logic [3:0]         dbg_state
);
    localparam int BEATS  = INSTR_W / DATA_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [DATA_W-1:0] CMD_LOAD = DATA_W'(8'hA0);
    localparam logic [DATA_W-1:0] CMD_READ = DATA_W'(8'hB0);
    localparam logic [DATA_W-1:0] CMD_RUN  = DATA_W'(8'hC0);
    localparam logic [DATA_W-1:0] CMD_HALT = DATA_W'(8'hD0);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_LEN, ST_LOAD, ST_WRITE, ST_RDREQ, ST_RDWAIT, ST_RDOUT, ST_RUN
    } state_t;

    state_t             state;
    logic               is_read;
    logic [ADDR_W-1:0]  addr;
    logic [7:0]         remaining;  // words still to go after the current one
    logic [BEAT_W-1:0]  beat;
    logic [INSTR_W-1:0] word;

    logic               in_fire;
    logic               out_fire;
    logic               last_beat;
    logic [INSTR_W-1:0] word_shift;
    logic [INSTR_W-1:0] word_in;

    assign in_fire    = bus.in_valid && bus.in_ready;
    assign out_fire   = bus.out_valid && bus.out_ready;
    assign last_beat  = (beat == BEAT_W'(BEATS - 1));
    assign word_shift = word >> DATA_W;
    // Incoming bytes enter at the top so the first (LSB) byte ends up at bit 0.
    assign word_in    = word_shift | (INSTR_W'(bus.in_data) << (INSTR_W - DATA_W));
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            is_read      <= 1'b0;
            addr         <= '0;
            remaining    <= '0;
            beat         <= '0;
            word         <= '0;
            bus.in_ready <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            mem_we       <= 1'b0;
            mem_re       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_run      <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (in_fire) begin
                        if (bus.in_data == CMD_LOAD || bus.in_data == CMD_READ) begin
                            is_read <= (bus.in_data == CMD_READ);
                            busy    <= 1'b1;
                            state   <= ST_ADDR;
                        end else if (bus.in_data == CMD_RUN) begin
                            cpu_run <= 1'b1;
                            state   <= ST_RUN;
                        end else if (bus.in_data != CMD_HALT) begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_ADDR: if (in_fire) begin
                    addr  <= ADDR_W'(bus.in_data);
                    state <= ST_LEN;
                end
                ST_LEN: if (in_fire) begin
                    remaining <= 8'(bus.in_data);
                    beat      <= '0;
                    if (is_read) begin
                        bus.in_ready <= 1'b0;
                        mem_re       <= 1'b1;
                        mem_addr     <= addr;
                        state        <= ST_RDREQ;
                    end else begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: if (in_fire) begin
                    word <= word_in;
                    if (last_beat) begin
                        beat         <= '0;
                        bus.in_ready <= 1'b0;
                        mem_we       <= 1'b1;
                        mem_addr     <= addr;
                        mem_wdata    <= word_in;
                        state        <= ST_WRITE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                ST_WRITE: begin
                    addr         <= addr + 1'b1;
                    remaining    <= remaining - 8'd1;
                    bus.in_ready <= 1'b1;
                    if (remaining == 8'd0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_LOAD;
                    end
                end
                ST_RDREQ: state <= ST_RDWAIT;
                ST_RDWAIT: begin
                    word          <= mem_rdata;
                    bus.out_data  <= mem_rdata[DATA_W-1:0];
                    bus.out_valid <= 1'b1;
                    beat          <= '0;
                    state         <= ST_RDOUT;
                end
                ST_RDOUT: if (out_fire) begin
                    if (last_beat) begin
                        bus.out_valid <= 1'b0;
                        addr          <= addr + 1'b1;
                        remaining     <= remaining - 8'd1;
                        if (remaining == 8'd0) begin
                            busy         <= 1'b0;
                            bus.in_ready <= 1'b1;
                            state        <= ST_IDLE;
                        end else begin
                            mem_re   <= 1'b1;
                            mem_addr <= addr + 1'b1;
                            state    <= ST_RDREQ;
                        end
                    end else begin
                        word         <= word_shift;
                        bus.out_data <= word_shift[DATA_W-1:0];
                        beat         <= beat + 1'b1;
                    end
                end
                ST_RUN: if (in_fire) begin
                    if (bus.in_data == CMD_HALT) begin
                        cpu_run <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        err <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tt_prog_loader.sv
// Randomised scoreboard bench for tt_prog_loader: expected RAM writes and readback bytes
// come from a word-level model of program memory.
module tb_tt_prog_loader;
    localparam int DATA_W  = 8;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 32;
    localparam int ADDR_W  = 5;
    localparam int BEATS   = INSTR_W / DATA_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               mem_we, mem_re, cpu_run, busy, err;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_wdata;
    logic [INSTR_W-1:0] mem_rdata;
    logic [3:0]         dbg_state;

    tt_prog_loader_if #(.DATA_W(DATA_W)) bus ();

    tt_prog_loader #(.DATA_W(DATA_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cpu_run(cpu_run), .busy(busy), .err(err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / program RAM ----------------
    always #5 clk = ~clk;

    logic               ram_clr = 1'b1;
    logic [INSTR_W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int exp_err = 0;
    int out_cnt = 0;
    int stall_hits = 0;
    int gap_max = 0;
    int ready_mode = 0;  // 0: always ready, 1: random, 2: manual_ready
    logic manual_ready = 1'b1;

    logic [ADDR_W+INSTR_W-1:0] exp_wr_q[$];
    logic [DATA_W-1:0]         exp_out_q[$];
    logic [INSTR_W-1:0]        words_q[$];
    logic [INSTR_W-1:0]        model_ram [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [ADDR_W+INSTR_W-1:0] ew;
        logic [DATA_W-1:0]         eb;
        logic                      stall_prev;
        logic [DATA_W-1:0]         stall_data;
        stall_prev = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (mem_we) begin
                    check("write_expected", 32'(exp_wr_q.size() != 0), 1);
                    check("ready_low_in_write", 32'(bus.in_ready), 0);
                    if (exp_wr_q.size() != 0) begin
                        ew = exp_wr_q.pop_front();
                        check("mem_write", 32'({mem_addr, mem_wdata}), 32'(ew));
                    end
                end
                if (mem_we || mem_re) check("we_re_exclusive", 32'(mem_we && mem_re), 0);
                if (busy) check("run_while_busy", 32'(cpu_run), 0);
                if (stall_prev) begin
                    stall_hits++;
                    check("stall_valid", 32'(bus.out_valid), 1);
                    check("stall_data", 32'(bus.out_data), 32'(stall_data));
                end
                if (bus.out_valid && bus.out_ready) begin
                    out_cnt++;
                    check("out_expected", 32'(exp_out_q.size() != 0), 1);
                    if (exp_out_q.size() != 0) begin
                        eb = exp_out_q.pop_front();
                        check("out_byte", 32'(bus.out_data), 32'(eb));
                    end
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                stall_data = bus.out_data;
                if (err) err_seen++;
            end
        end
    end

    // ---------------- out_ready driver ----------------
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (ready_mode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
            else if (ready_mode == 2) bus.out_ready = manual_ready;
            else bus.out_ready = 1'b1;
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic send_byte(input logic [7:0] b);
        int n;
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                check("in_ready_timeout", 32'(bus.in_ready), 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((busy || exp_wr_q.size() != 0 || exp_out_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("done_in_budget", 32'(n < 3000), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_err();
        @(negedge clk);
        @(posedge clk);
        #1;
        check("err_count", 32'(err_seen), 32'(exp_err));
    endtask

    task automatic do_reset(input logic clr);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        ram_clr = clr;
        repeat (2) @(posedge clk);
        #1 ram_clr = 1'b0;
        @(negedge clk);
        check("reset_ctrl", 32'({bus.in_ready, bus.out_valid, mem_we, mem_re, cpu_run, busy, err}), 0);
        check("reset_data", 32'({bus.out_data, mem_addr, mem_wdata}), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    // Load n words starting at byte a: words from words_q first, then random.
    task automatic issue_load(input int a, input int n);
        logic [INSTR_W-1:0] w;
        int                 wa;
        send_byte(8'hA0);
        send_byte(8'(a));
        send_byte(8'(n - 1));
        for (int i = 0; i < n; i++) begin
            w  = (words_q.size() != 0) ? words_q.pop_front() : INSTR_W'($urandom);
            wa = (a + i) % DEPTH;
            model_ram[wa] = w;
            exp_wr_q.push_back({ADDR_W'(wa), w});
            for (int k = 0; k < BEATS; k++) send_byte(w[k*DATA_W +: DATA_W]);
        end
        wait_done();
    endtask

    task automatic push_read(input int a, input int n);
        logic [INSTR_W-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = model_ram[(a + i) % DEPTH];
            for (int k = 0; k < BEATS; k++) exp_out_q.push_back(w[k*DATA_W +: DATA_W]);
        end
    endtask

    task automatic issue_read(input int a, input int n);
        push_read(a, n);
        send_byte(8'hB0);
        send_byte(8'(a));
        send_byte(8'(n - 1));
        wait_done();
    endtask

    task automatic run_session(input int bad_bytes);
        logic [7:0] b;
        send_byte(8'hC0);
        @(negedge clk);
        check("run_after_c0", 32'(cpu_run), 1);
        check("run_not_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < bad_bytes; i++) begin
            b = 8'($urandom_range(0, 255));
            while (b == 8'hD0) b = 8'($urandom_range(0, 255));
            send_byte(b);
            exp_err++;
            @(negedge clk);
            check("err_in_run", 32'(err), 1);
            check("run_held", 32'(cpu_run), 1);
            @(posedge clk);
            #1;
        end
        send_byte(8'hD0);
        @(negedge clk);
        check("halted", 32'(cpu_run), 0);
        check("halt_idle", 32'({busy, bus.in_ready}), 32'(2'b01));
        @(posedge clk);
        #1;
        check_err();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int         start;
        int         n;
        int         stalls_before;
        int         op;
        logic [7:0] b;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        for (int i = 0; i < DEPTH; i++) model_ram[i] = '0;

        do_reset(1'b1);

        // Directed load of two words at address 5.
        words_q.push_back(16'h1234);
        words_q.push_back(16'h5678);
        issue_load(5, 2);
        check("load_idle", 32'({busy, cpu_run, bus.in_ready}), 32'(3'b001));

        // Wrap-around load at 31, then readback with a 3-cycle consumer stall mid-word.
        issue_load(31, 2);
        ready_mode    = 2;
        manual_ready  = 1'b1;
        start         = out_cnt;
        stalls_before = stall_hits;
        push_read(31, 2);
        send_byte(8'hB0);
        send_byte(8'h1F);
        send_byte(8'h01);
        n = 0;
        while (out_cnt < start + 1 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("first_byte_seen", 32'(out_cnt >= start + 1), 1);
        #1 manual_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 manual_ready = 1'b1;
        wait_done();
        check("stall_observed", 32'(stall_hits - stalls_before >= 3), 1);
        check("read_byte_count", 32'(out_cnt - start), 32'(2 * BEATS));
        ready_mode = 0;

        // Run, one rejected byte, halt.
        run_session(1);

        // Unknown command in IDLE.
        send_byte(8'h55);
        exp_err++;
        @(negedge clk);
        check("bad_cmd_err", 32'(err), 1);
        check("bad_cmd_idle", 32'({busy, cpu_run, bus.in_ready}), 32'(3'b001));
        @(posedge clk);
        #1;
        check_err();

        // Reset in the middle of a word: nothing may be written.
        send_byte(8'hA0);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hAB);
        do_reset(1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("no_write_after_reset", 32'(exp_wr_q.size()), 0);

        // Randomised traffic.
        gap_max    = 2;
        ready_mode = 1;
        for (int t = 0; t < 40; t++) begin
            op = $urandom_range(0, 9);
            n  = ($urandom_range(0, 7) == 0) ? $urandom_range(33, 40) : $urandom_range(1, 4);
            if (op <= 3) begin
                issue_load($urandom_range(0, 255), n);
            end else if (op <= 6) begin
                issue_read($urandom_range(0, 255), n);
            end else if (op == 7) begin
                run_session($urandom_range(0, 2));
            end else if (op == 8) begin
                b = 8'($urandom_range(0, 255));
                while (b == 8'hA0 || b == 8'hB0 || b == 8'hC0 || b == 8'hD0)
                    b = 8'($urandom_range(0, 255));
                send_byte(b);
                exp_err++;
                check_err();
            end else begin
                send_byte(8'hD0);
                @(negedge clk);
                check("halt_noop", 32'({busy, cpu_run, err}), 0);
                @(posedge clk);
                #1;
            end
        end
        ready_mode = 0;
        // Full readback of memory against the model.
        issue_read(0, DEPTH);
        check_err();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: time limit reached, required completion before it");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end
endmodule
